// File: rtl/led_fifo_if.sv
// Handshake bundle between the zone-data producer/consumer and the LED FIFO.
interface led_fifo_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  wr_en;
   logic                  wr_full;
   logic                  almost_full;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_empty;
   logic                  almost_empty;

   modport master (
      output wr_data, wr_en, rd_en,
      input  wr_full, almost_full, rd_data, rd_empty, almost_empty
   );

   modport slave (
      input  wr_data, wr_en, rd_en,
      output wr_full, almost_full, rd_data, rd_empty, almost_empty
   );
endinterface

// File: rtl/led_fifo.sv
// Single-clock FIFO for LED/backlight zone data. Pointers carry a wrap bit so
// occupancy is simply wr_ptr - rd_ptr; all flags are registered from the
// post-edge occupancy, so no output depends combinationally on wr_en/rd_en.
module led_fifo #(
   parameter int DEPTH_WIDTH      = 10,
   parameter int DATA_WIDTH       = 8,
   parameter int ALMOST_FULL_NUM  = 1020,
   parameter int ALMOST_EMPTY_NUM = 4
) (
   input logic        clk,
   input logic        rst,
   led_fifo_if.slave  bus
);
   localparam int DEPTH = 1 << DEPTH_WIDTH;
   localparam logic [DEPTH_WIDTH:0] FULL_CNT = {1'b1, {DEPTH_WIDTH{1'b0}}};
   localparam logic [DEPTH_WIDTH:0] AF_CNT   = ALMOST_FULL_NUM[DEPTH_WIDTH:0];
   localparam logic [DEPTH_WIDTH:0] AE_CNT   = ALMOST_EMPTY_NUM[DEPTH_WIDTH:0];

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DEPTH_WIDTH:0]  wr_ptr;
   logic [DEPTH_WIDTH:0]  rd_ptr;
   logic [DEPTH_WIDTH:0]  wr_ptr_nxt;
   logic [DEPTH_WIDTH:0]  rd_ptr_nxt;
   logic [DEPTH_WIDTH:0]  cnt_nxt;
   logic                  wr_acc;
   logic                  rd_acc;

   // Accept decisions use the registered flags, which are exact.
   always_comb begin
      wr_acc     = bus.wr_en & ~bus.wr_full;
      rd_acc     = bus.rd_en & ~bus.rd_empty;
      wr_ptr_nxt = wr_ptr + {{DEPTH_WIDTH{1'b0}}, wr_acc};
      rd_ptr_nxt = rd_ptr + {{DEPTH_WIDTH{1'b0}}, rd_acc};
      cnt_nxt    = wr_ptr_nxt - rd_ptr_nxt;
   end

   // Pointers and flags advance together so flags always match occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         bus.wr_full      <= 1'b0;
         bus.almost_full  <= 1'b0;
         bus.rd_empty     <= 1'b1;
         bus.almost_empty <= 1'b1;
      end else begin
         wr_ptr           <= wr_ptr_nxt;
         rd_ptr           <= rd_ptr_nxt;
         bus.wr_full      <= (cnt_nxt == FULL_CNT);
         bus.almost_full  <= (cnt_nxt >= AF_CNT);
         bus.rd_empty     <= (cnt_nxt == '0);
         bus.almost_empty <= (cnt_nxt <= AE_CNT);
      end
   end

   // Storage array; contents survive reset, only the pointers are cleared.
   always_ff @(posedge clk) begin
      if (!rst && wr_acc)
         mem[wr_ptr[DEPTH_WIDTH-1:0]] <= bus.wr_data;
   end

   // Registered read port; holds its value when no read is accepted.
   always_ff @(posedge clk) begin
      if (rst)
         bus.rd_data <= '0;
      else if (rd_acc)
         bus.rd_data <= mem[rd_ptr[DEPTH_WIDTH-1:0]];
   end
endmodule

// File: tb/tb_led_fifo.sv
// Directed bench for led_fifo: fill/drain with overflow and underflow,
// steady-state simultaneous traffic across pointer wrap, corner accepts,
// and mid-stream reset.
module tb_led_fifo;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   logic [7:0] last_rd = 8'h00;

   led_fifo_if #(.DATA_WIDTH(8)) bus ();

   led_fifo dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // {wr_full, almost_full, almost_empty, rd_empty} for a given occupancy
   function automatic logic [3:0] exp_flags(input int cnt);
      return {cnt == 1024, cnt >= 1020, cnt <= 4, cnt == 0};
   endfunction

   function automatic logic [3:0] obs_flags();
      return {bus.wr_full, bus.almost_full, bus.almost_empty, bus.rd_empty};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      bus.wr_data = 8'h00;
      repeat (20) step();
      rst = 1'b0;
      step();
      checks++;
      if (obs_flags() !== 4'b0011) begin
         errors++;
         $display("FAIL reset_flags got=%b exp=%b", obs_flags(), 4'b0011);
      end
      checks++;
      if (bus.rd_data !== 8'h00) begin
         errors++;
         $display("FAIL reset_rd_data got=%h exp=00", bus.rd_data);
      end
      last_rd = 8'h00;
   endtask

   task automatic test_fill_overflow();
      int cnt = 0;
      for (int i = 0; i < 1025; i++) begin
         bus.wr_data = 8'hFF - 8'(i);
         bus.wr_en   = 1'b1;
         step();
         if (cnt < 1024) cnt++;
         checks++;
         if (obs_flags() !== exp_flags(cnt)) begin
            errors++;
            $display("FAIL fill_flags write=%0d got=%b exp=%b", i + 1, obs_flags(), exp_flags(cnt));
         end
      end
      bus.wr_en = 1'b0;
   endtask

   task automatic test_drain_underflow();
      int cnt = 1024;
      int k = 0;
      for (int i = 0; i < 1025; i++) begin
         bus.rd_en = 1'b1;
         step();
         if (cnt > 0) begin
            last_rd = 8'hFF - 8'(k);
            k++;
            cnt--;
         end
         checks++;
         if (bus.rd_data !== last_rd) begin
            errors++;
            $display("FAIL drain_data read=%0d got=%h exp=%h", i + 1, bus.rd_data, last_rd);
         end
         checks++;
         if (obs_flags() !== exp_flags(cnt)) begin
            errors++;
            $display("FAIL drain_flags read=%0d got=%b exp=%b", i + 1, obs_flags(), exp_flags(cnt));
         end
      end
      bus.rd_en = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [7:0] q[$];
      logic [7:0] d;
      for (int i = 0; i < 500; i++) begin
         d = 8'(i * 7 + 3);
         bus.wr_data = d;
         bus.wr_en = 1'b1;
         step();
         q.push_back(d);
      end
      for (int i = 0; i < 2000; i++) begin
         d = 8'(i * 13 + 1);
         bus.wr_data = d;
         bus.wr_en = 1'b1;
         bus.rd_en = 1'b1;
         step();
         last_rd = q.pop_front();
         q.push_back(d);
         checks++;
         if (bus.rd_data !== last_rd) begin
            errors++;
            $display("FAIL b2b_data cycle=%0d got=%h exp=%h", i, bus.rd_data, last_rd);
         end
         checks++;
         if (obs_flags() !== exp_flags(500)) begin
            errors++;
            $display("FAIL b2b_flags cycle=%0d got=%b exp=%b", i, obs_flags(), exp_flags(500));
         end
      end
      bus.wr_en = 1'b0;
      for (int i = 0; i < 500; i++) begin
         bus.rd_en = 1'b1;
         step();
         last_rd = q.pop_front();
         checks++;
         if (bus.rd_data !== last_rd) begin
            errors++;
            $display("FAIL b2b_drain idx=%0d got=%h exp=%h", i, bus.rd_data, last_rd);
         end
      end
      bus.rd_en = 1'b0;
      checks++;
      if (obs_flags() !== 4'b0011) begin
         errors++;
         $display("FAIL b2b_end_flags got=%b exp=%b", obs_flags(), 4'b0011);
      end
   endtask

   task automatic test_rw_empty();
      bus.wr_data = 8'hA5;
      bus.wr_en = 1'b1;
      bus.rd_en = 1'b1;
      step();
      checks++;
      if (obs_flags() !== exp_flags(1)) begin
         errors++;
         $display("FAIL rw_empty_flags got=%b exp=%b", obs_flags(), exp_flags(1));
      end
      checks++;
      if (bus.rd_data !== last_rd) begin
         errors++;
         $display("FAIL rw_empty_hold got=%h exp=%h", bus.rd_data, last_rd);
      end
      bus.wr_en = 1'b0;
      step();
      last_rd = 8'hA5;
      checks++;
      if (bus.rd_data !== 8'hA5) begin
         errors++;
         $display("FAIL rw_empty_data got=%h exp=a5", bus.rd_data);
      end
      checks++;
      if (obs_flags() !== 4'b0011) begin
         errors++;
         $display("FAIL rw_empty_after got=%b exp=%b", obs_flags(), 4'b0011);
      end
      bus.rd_en = 1'b0;
   endtask

   task automatic test_rw_full();
      for (int i = 0; i < 1024; i++) begin
         bus.wr_data = 8'(i);
         bus.wr_en = 1'b1;
         step();
      end
      checks++;
      if (obs_flags() !== 4'b1100) begin
         errors++;
         $display("FAIL rw_full_pre got=%b exp=%b", obs_flags(), 4'b1100);
      end
      bus.wr_data = 8'hEE;
      bus.rd_en = 1'b1;
      step();
      bus.wr_en = 1'b0;
      last_rd = 8'h00;
      checks++;
      if (bus.rd_data !== 8'h00) begin
         errors++;
         $display("FAIL rw_full_data got=%h exp=00", bus.rd_data);
      end
      checks++;
      if (obs_flags() !== exp_flags(1023)) begin
         errors++;
         $display("FAIL rw_full_flags got=%b exp=%b", obs_flags(), exp_flags(1023));
      end
      for (int i = 1; i < 1024; i++) begin
         step();
         last_rd = 8'(i);
         checks++;
         if (bus.rd_data !== last_rd) begin
            errors++;
            $display("FAIL rw_full_drain idx=%0d got=%h exp=%h", i, bus.rd_data, last_rd);
         end
      end
      step();
      checks++;
      if (bus.rd_data !== last_rd) begin
         errors++;
         $display("FAIL rw_full_dropped got=%h exp=%h", bus.rd_data, last_rd);
      end
      checks++;
      if (obs_flags() !== 4'b0011) begin
         errors++;
         $display("FAIL rw_full_end got=%b exp=%b", obs_flags(), 4'b0011);
      end
      bus.rd_en = 1'b0;
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 300; i++) begin
         bus.wr_data = 8'(i + 17);
         bus.wr_en = 1'b1;
         step();
      end
      bus.wr_en = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (obs_flags() !== 4'b0011) begin
         errors++;
         $display("FAIL midrst_flags got=%b exp=%b", obs_flags(), 4'b0011);
      end
      checks++;
      if (bus.rd_data !== 8'h00) begin
         errors++;
         $display("FAIL midrst_rd_data got=%h exp=00", bus.rd_data);
      end
      bus.wr_data = 8'h5A;
      bus.wr_en = 1'b1;
      step();
      bus.wr_en = 1'b0;
      checks++;
      if (obs_flags() !== exp_flags(1)) begin
         errors++;
         $display("FAIL midrst_write got=%b exp=%b", obs_flags(), exp_flags(1));
      end
      bus.rd_en = 1'b1;
      step();
      bus.rd_en = 1'b0;
      checks++;
      if (bus.rd_data !== 8'h5A) begin
         errors++;
         $display("FAIL midrst_read got=%h exp=5a", bus.rd_data);
      end
      checks++;
      if (obs_flags() !== 4'b0011) begin
         errors++;
         $display("FAIL midrst_end got=%b exp=%b", obs_flags(), 4'b0011);
      end
   endtask

   initial begin
      test_reset();
      test_fill_overflow();
      test_drain_underflow();
      test_back_to_back();
      test_rw_empty();
      test_rw_full();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
